// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
//
// Moore-style control FSM for the multi-cycle MIPS-32 core. Sequences fetch,
// decode, execute, memory and write-back over several cycles, stalls on the
// memory ready handshake, traps illegal opcodes and counts retired
// instructions.
//
// Parameters:
//   EXT_OPS         - 1: addi / bne are supported; 0: both are illegal
//   HALT_ON_ILLEGAL - 1: park in HALT on an illegal opcode; 0: skip and refetch
//   CNT_W           - width of the retired-instruction counter
//
// Ports:
//   clk, rst_n      - rising-edge clock, asynchronous active-low reset
//   opcode[5:0]     - IR[31:26], sampled in DECODE and MEMADR only
//   mem_ready       - current memory access completes this cycle
//   PCWrite .. RegDst, ALUOp, ALUSrcB, PCSource - datapath controls
//   illegal         - one-cycle pulse in DECODE on an unsupported opcode
//   halted          - high while parked in HALT
//   retired         - completed-instruction count, wraps modulo 2^CNT_W
// -----------------------------------------------------------------------------
module multicycle_control #(
    parameter bit          EXT_OPS         = 1'b1,
    parameter bit          HALT_ON_ILLEGAL = 1'b1,
    parameter int unsigned CNT_W           = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             BranchNE,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             MemtoReg,
    output logic             IRWrite,
    output logic             ALUSrcA,
    output logic             RegWrite,
    output logic             RegDst,
    output logic [1:0]       ALUOp,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       PCSource,
    output logic             illegal,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [3:0] {
        S_RST, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
        S_EXEC, S_RWB, S_BRANCH, S_JUMP, S_ADDIEX, S_ADDIWB, S_HALT
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam state_t ILL_NEXT = HALT_ON_ILLEGAL ? S_HALT : S_FETCH;

    state_t state, next_state;
    logic   retire;
    // Branch flavour is captured in DECODE so that BRANCH decodes from
    // registered state only and ignores later opcode changes.
    logic   bne_q;

    function automatic logic op_legal(input logic [5:0] op);
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J: return 1'b1;
            OP_BNE, OP_ADDI:                      return EXT_OPS;
            default:                              return 1'b0;
        endcase
    endfunction

    // State register, branch flavour and retired counter.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_RST;
            bne_q   <= 1'b0;
            retired <= '0;
        end else begin
            state <= next_state;
            if (state == S_DECODE)
                bne_q <= (opcode == OP_BNE);
            if (retire)
                retired <= retired + CNT_W'(1);
        end
    end

    // Next-state logic; retire marks every completing transition into FETCH.
    always_comb begin
        next_state = state;
        retire     = 1'b0;
        case (state)
            S_RST:    next_state = S_FETCH;
            S_FETCH:  if (mem_ready) next_state = S_DECODE;
            S_DECODE: begin
                if (!op_legal(opcode)) begin
                    next_state = ILL_NEXT;
                end else begin
                    case (opcode)
                        OP_RTYPE:       next_state = S_EXEC;
                        OP_LW, OP_SW:   next_state = S_MEMADR;
                        OP_BEQ, OP_BNE: next_state = S_BRANCH;
                        OP_J:           next_state = S_JUMP;
                        OP_ADDI:        next_state = S_ADDIEX;
                        default:        next_state = ILL_NEXT;
                    endcase
                end
            end
            S_MEMADR: next_state = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (mem_ready) next_state = S_MEMWB;
            S_MEMWR: begin
                if (mem_ready) begin
                    next_state = S_FETCH;
                    retire     = 1'b1;
                end
            end
            S_MEMWB, S_RWB, S_BRANCH, S_JUMP, S_ADDIWB: begin
                next_state = S_FETCH;
                retire     = 1'b1;
            end
            S_EXEC:   next_state = S_RWB;
            S_ADDIEX: next_state = S_ADDIWB;
            S_HALT:   next_state = S_HALT;
            default:  next_state = S_RST;
        endcase
    end

    // Output decode from registered state (FETCH strobes gated by mem_ready).
    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        BranchNE    = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        MemtoReg    = 1'b0;
        IRWrite     = 1'b0;
        ALUSrcA     = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        ALUOp       = 2'b00;
        ALUSrcB     = 2'b00;
        PCSource    = 2'b00;
        illegal     = 1'b0;
        halted      = 1'b0;
        case (state)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                illegal = !op_legal(opcode);
            end
            S_MEMADR, S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            S_MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
            end
            S_RWB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
                BranchNE    = bne_q;
            end
            S_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
            end
            S_ADDIWB: RegWrite = 1'b1;
            S_HALT:   halted   = 1'b1;
            default: ;
        endcase
    end

endmodule
